// File: rtl/sr_strobe_gen_pkg.sv
// Shared definitions for the SR latch strobe generator: strobe FSM encoding
// and which key_n bit carries which request.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SET_ACT = 2'd1,
        RST_ACT = 2'd2
    } sr_state_t;

    localparam int KEY_SET = 1;
    localparam int KEY_RST = 0;

endpackage

// File: rtl/sr_strobe_gen_key_debounce.sv
// One button: two-flop synchroniser, stable-count debounce, and a one-cycle
// press pulse on the debounced 1->0 transition (release is ignored).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             deb_d;
    logic [CNT_W-1:0] cnt;

    // Any return of sync2 to the accepted level restarts the stability count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            deb   <= 1'b1;
            deb_d <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            deb_d <= deb;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press = deb_d & ~deb;

endmodule

// File: rtl/sr_strobe_gen.sv
// Debounced push-buttons to fixed-width active-low Sn/Rn strobes for an SR
// latch; Sn and Rn are never low together.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  IDLE    | no strobe active, nothing pending
//  SET_ACT | Sn held low, pulse counter running down to 0
//  RST_ACT | Rn held low, pulse counter running down to 0
module sr_strobe_gen
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PULSE_LEN       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] key_n,
    output logic       Sn,
    output logic       Rn,
    output logic       busy,
    output logic       conflict
);

    localparam int PCNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    logic [1:0]        press;
    logic              set_ev;
    logic              rst_ev;
    sr_state_t         state;
    sr_state_t         state_nxt;
    logic [PCNT_W-1:0] pcnt;
    logic [PCNT_W-1:0] pcnt_nxt;
    logic              pend_set;
    logic              pend_set_nxt;
    logic              pend_rst;
    logic              pend_rst_nxt;
    logic              conflict_nxt;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n[KEY_SET]),
        .press (press[KEY_SET])
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_rst (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n[KEY_RST]),
        .press (press[KEY_RST])
    );

    assign set_ev = press[KEY_SET];
    assign rst_ev = press[KEY_RST];

    // Draining looks at the pending flags including this cycle's events, so a
    // press landing on the last strobe cycle is still issued without a gap.
    always_comb begin
        state_nxt    = state;
        pcnt_nxt     = pcnt;
        pend_set_nxt = pend_set;
        pend_rst_nxt = pend_rst;
        conflict_nxt = 1'b0;
        case (state)
            IDLE: begin
                pcnt_nxt = PCNT_W'(PULSE_LEN - 1);
                if (set_ev && rst_ev) begin
                    conflict_nxt = 1'b1;
                end else if (set_ev) begin
                    state_nxt = SET_ACT;
                end else if (rst_ev) begin
                    state_nxt = RST_ACT;
                end
            end
            SET_ACT: begin
                if (set_ev) pend_set_nxt = 1'b1;
                if (rst_ev) pend_rst_nxt = 1'b1;
                if (pcnt == '0) begin
                    pcnt_nxt = PCNT_W'(PULSE_LEN - 1);
                    if (pend_rst_nxt) begin
                        state_nxt    = RST_ACT;
                        pend_rst_nxt = 1'b0;
                    end else if (pend_set_nxt) begin
                        state_nxt    = SET_ACT;
                        pend_set_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    pcnt_nxt = pcnt - PCNT_W'(1);
                end
            end
            RST_ACT: begin
                if (set_ev) pend_set_nxt = 1'b1;
                if (rst_ev) pend_rst_nxt = 1'b1;
                if (pcnt == '0) begin
                    pcnt_nxt = PCNT_W'(PULSE_LEN - 1);
                    if (pend_set_nxt) begin
                        state_nxt    = SET_ACT;
                        pend_set_nxt = 1'b0;
                    end else if (pend_rst_nxt) begin
                        state_nxt    = RST_ACT;
                        pend_rst_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    pcnt_nxt = pcnt - PCNT_W'(1);
                end
            end
            default: begin
                state_nxt    = IDLE;
                pend_set_nxt = 1'b0;
                pend_rst_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pcnt     <= '0;
            pend_set <= 1'b0;
            pend_rst <= 1'b0;
            Sn       <= 1'b1;
            Rn       <= 1'b1;
            busy     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= state_nxt;
            pcnt     <= pcnt_nxt;
            pend_set <= pend_set_nxt;
            pend_rst <= pend_rst_nxt;
            Sn       <= (state_nxt != SET_ACT);
            Rn       <= (state_nxt != RST_ACT);
            busy     <= (state_nxt != IDLE) | pend_set_nxt | pend_rst_nxt;
            conflict <= conflict_nxt;
        end
    end

endmodule

// File: tb/tb_sr_strobe_gen.sv
// Scoreboard bench for sr_strobe_gen with DEBOUNCE_CYCLES=4, PULSE_LEN=2:
// expected pulses and level snapshots are queued by the stimulus, the monitor
// measures every pulse on Sn/Rn/conflict and compares.
module tb_sr_strobe_gen;

    typedef struct {
        int kind;   // 0=Sn low, 1=Rn low, 2=conflict high
        int start;
        int width;
    } pulse_t;

    typedef struct {
        int   at;
        logic sn;
        logic rn;
        logic busy;
        logic conf;
    } lvl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] key_n;
    logic       Sn;
    logic       Rn;
    logic       busy;
    logic       conflict;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         e0;
    pulse_t     exp_q[$];
    lvl_t       lvl_q[$];
    int         drain_q[$];
    logic [2:0] prev_act = 3'b000;
    int         pstart[3];
    string      pname[3] = '{"Sn", "Rn", "conflict"};

    sr_strobe_gen #(.DEBOUNCE_CYCLES(4), .PULSE_LEN(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .key_n    (key_n),
        .Sn       (Sn),
        .Rn       (Rn),
        .busy     (busy),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_pulse(input int kind, input int start, input int width);
        pulse_t p;
        p.kind  = kind;
        p.start = start;
        p.width = width;
        exp_q.push_back(p);
    endtask

    task automatic exp_lvl(input logic sn, input logic rn, input logic b, input logic c);
        lvl_t l;
        l.at   = cyc;
        l.sn   = sn;
        l.rn   = rn;
        l.busy = b;
        l.conf = c;
        lvl_q.push_back(l);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, so cyc names the last rising edge.
    always @(negedge clk) begin
        logic [2:0] act;
        int         idx;
        act = {conflict, ~Rn, ~Sn};

        checks++;
        if (!Sn && !Rn) begin
            errors++;
            $display("FAIL overlap cyc=%0d: Sn=%b Rn=%b, required not both 0", cyc, Sn, Rn);
        end

        for (int k = 0; k < 3; k++) begin
            if (act[k] && !prev_act[k]) pstart[k] = cyc;
            if (!act[k] && prev_act[k]) begin
                idx = -1;
                for (int q = 0; q < exp_q.size(); q++)
                    if (idx < 0 && exp_q[q].kind == k) idx = q;
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL unexpected_%s pulse: start=%0d width=%0d, required none",
                             pname[k], pstart[k], cyc - pstart[k]);
                end else begin
                    if (exp_q[idx].start != pstart[k] || exp_q[idx].width != cyc - pstart[k]) begin
                        errors++;
                        $display("FAIL %s_pulse: start=%0d width=%0d, required start=%0d width=%0d",
                                 pname[k], pstart[k], cyc - pstart[k],
                                 exp_q[idx].start, exp_q[idx].width);
                    end
                    exp_q.delete(idx);
                end
            end
        end
        prev_act = act;

        while (lvl_q.size() > 0 && lvl_q[0].at <= cyc) begin
            checks++;
            if (lvl_q[0].at != cyc) begin
                errors++;
                $display("FAIL level_missed at=%0d: sampled at %0d, required at %0d",
                         lvl_q[0].at, cyc, lvl_q[0].at);
            end else if (Sn !== lvl_q[0].sn || Rn !== lvl_q[0].rn ||
                         busy !== lvl_q[0].busy || conflict !== lvl_q[0].conf) begin
                errors++;
                $display("FAIL level cyc=%0d: Sn/Rn/busy/conflict=%b%b%b%b, required %b%b%b%b",
                         cyc, Sn, Rn, busy, conflict,
                         lvl_q[0].sn, lvl_q[0].rn, lvl_q[0].busy, lvl_q[0].conf);
            end
            void'(lvl_q.pop_front());
        end

        while (drain_q.size() > 0 && drain_q[0] <= cyc) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_pulse cyc=%0d: %0d outstanding (first %s start=%0d), required 0",
                         cyc, exp_q.size(), pname[exp_q[0].kind], exp_q[0].start);
                exp_q.delete();
            end
            void'(drain_q.pop_front());
        end
    end

    initial begin
        reset = 1'b1;
        key_n = 2'b11;
        @(posedge clk); #1;
        exp_lvl(1'b1, 1'b1, 1'b0, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(3);

        // Set key pressed and held: one 2-cycle Sn pulse at edges 7..8.
        tick(1); e0 = cyc;
        key_n[1] = 1'b0;
        exp_pulse(0, e0 + 7, 2);
        tick(7);
        exp_lvl(1'b0, 1'b1, 1'b1, 1'b0);
        tick(13);
        key_n[1] = 1'b1;
        tick(12); drain_q.push_back(cyc);

        // Bounce on the set key (2-cycle runs never reach the stable count).
        tick(1); e0 = cyc;
        for (int i = 0; i < 6; i++) begin
            key_n[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        key_n[1] = 1'b0;
        exp_pulse(0, e0 + 19, 2);
        tick(20);
        key_n[1] = 1'b1;
        tick(12); drain_q.push_back(cyc);

        // Both keys in the same cycle: no strobe, one-cycle conflict.
        tick(1); e0 = cyc;
        key_n = 2'b00;
        exp_pulse(2, e0 + 7, 1);
        tick(20);
        key_n = 2'b11;
        tick(12); drain_q.push_back(cyc);

        // Reset request accepted while Sn is low: Rn follows with no gap.
        tick(1); e0 = cyc;
        key_n[1] = 1'b0;
        exp_pulse(0, e0 + 7, 2);
        tick(1);
        key_n[0] = 1'b0;
        exp_pulse(1, e0 + 9, 2);
        tick(9);
        exp_lvl(1'b1, 1'b0, 1'b1, 1'b0);
        tick(2);
        exp_lvl(1'b1, 1'b1, 1'b0, 1'b0);
        tick(8);
        key_n = 2'b11;
        tick(12); drain_q.push_back(cyc);

        // Reset key held 100, released 10, pressed again: two Rn pulses.
        tick(1); e0 = cyc;
        key_n[0] = 1'b0;
        exp_pulse(1, e0 + 7, 2);
        tick(100);
        key_n[0] = 1'b1;
        tick(10);
        key_n[0] = 1'b0;
        exp_pulse(1, e0 + 117, 2);
        tick(20);
        key_n[0] = 1'b1;
        tick(12); drain_q.push_back(cyc);

        // Asynchronous reset in the middle of an Sn strobe.
        tick(1); e0 = cyc;
        key_n[1] = 1'b0;
        exp_pulse(0, e0 + 7, 1);
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        key_n = 2'b11;
        exp_lvl(1'b1, 1'b1, 1'b0, 1'b0);
        tick(3);
        reset = 1'b0;
        tick(25); drain_q.push_back(cyc);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
